// File: rtl/mmu_sram_if_if.sv
// rtl/mmu_sram_if_if.sv - CPU-side and SRAM-side signal bundle for mmu_sram_if
interface mmu_sram_if_if;
    logic        req;
    logic        rw_n;
    logic [23:0] padr_i;
    logic        wp_i;
    logic [7:0]  dbi;
    logic [7:0]  dbo;
    logic        rdy;
    logic        wp_fault;
    logic        busy;
    logic [23:0] sram_a;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [7:0]  sram_d_o;
    logic        sram_d_oe;
    logic [7:0]  sram_d_i;

    modport slave (
        input  req, rw_n, padr_i, wp_i, dbi, sram_d_i,
        output dbo, rdy, wp_fault, busy, sram_a,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_d_o, sram_d_oe
    );

    modport master (
        output req, rw_n, padr_i, wp_i, dbi, sram_d_i,
        input  dbo, rdy, wp_fault, busy, sram_a,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_d_o, sram_d_oe
    );
endinterface

// File: rtl/mmu_sram_if.sv
// rtl/mmu_sram_if.sv - byte-wide async SRAM cycle engine behind the memory mapper
module mmu_sram_if #(
    parameter int pWaitStates = 2
) (
    input logic          clk,
    input logic          rst,
    mmu_sram_if_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, FAULT} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(pWaitStates);

    state_t      state, state_nxt;
    logic        rd, rd_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [23:0] a_q, a_nxt;
    logic [7:0]  do_q, do_nxt;
    logic [7:0]  dbo_q, dbo_nxt;
    logic        ce_n_q, oe_n_q, we_n_q, d_oe_q, rdy_q, fault_q, busy_q;
    logic        ce_n_nxt, oe_n_nxt, we_n_nxt, d_oe_nxt, rdy_nxt, fault_nxt, busy_nxt;
    logic        act_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rd     <= 1'b1;
            cnt    <= 4'd0;
            a_q    <= 24'h000000;
            do_q   <= 8'h00;
            dbo_q  <= 8'h00;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            d_oe_q <= 1'b0;
            rdy_q  <= 1'b0;
            fault_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd     <= rd_nxt;
            cnt    <= cnt_nxt;
            a_q    <= a_nxt;
            do_q   <= do_nxt;
            dbo_q  <= dbo_nxt;
            ce_n_q <= ce_n_nxt;
            oe_n_q <= oe_n_nxt;
            we_n_q <= we_n_nxt;
            d_oe_q <= d_oe_nxt;
            rdy_q  <= rdy_nxt;
            fault_q <= fault_nxt;
            busy_q <= busy_nxt;
        end
    end

    // Outputs are decoded from the state being entered, so every strobe is a flop.
    always_comb begin
        state_nxt = state;
        rd_nxt    = rd;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        do_nxt    = do_q;
        dbo_nxt   = dbo_q;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (!bus.rw_n && bus.wp_i) begin
                        state_nxt = FAULT;
                    end else begin
                        a_nxt     = bus.padr_i;
                        do_nxt    = bus.dbi;
                        rd_nxt    = bus.rw_n;
                        cnt_nxt   = WAIT_LOAD;
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = HOLD;
                    if (rd) begin
                        dbo_nxt = bus.sram_d_i;
                    end
                end
            end
            HOLD:    state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        act_nxt   = (state_nxt == SETUP) || (state_nxt == ACCESS);
        ce_n_nxt  = !(act_nxt || (state_nxt == HOLD));
        oe_n_nxt  = !(act_nxt && rd_nxt);
        we_n_nxt  = !((state_nxt == ACCESS) && !rd_nxt);
        // Data stays driven through HOLD so it outlives the WE rising edge.
        d_oe_nxt  = (act_nxt || (state_nxt == HOLD)) && !rd_nxt;
        rdy_nxt   = (state_nxt == HOLD) || (state_nxt == FAULT);
        fault_nxt = (state_nxt == FAULT);
        busy_nxt  = (state_nxt != IDLE);
    end

    assign bus.dbo       = dbo_q;
    assign bus.rdy       = rdy_q;
    assign bus.wp_fault  = fault_q;
    assign bus.busy      = busy_q;
    assign bus.sram_a    = a_q;
    assign bus.sram_ce_n = ce_n_q;
    assign bus.sram_oe_n = oe_n_q;
    assign bus.sram_we_n = we_n_q;
    assign bus.sram_d_o  = do_q;
    assign bus.sram_d_oe = d_oe_q;

endmodule

// File: tb/tb_mmu_sram_if.sv
// tb/tb_mmu_sram_if.sv - directed vector bench for mmu_sram_if at W=1, 2 and 15
module tb_mmu_sram_if;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmu_sram_if_if bus2 ();
    mmu_sram_if_if bus1 ();
    mmu_sram_if_if bus15 ();

    mmu_sram_if #(.pWaitStates(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2.slave));
    mmu_sram_if #(.pWaitStates(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    mmu_sram_if #(.pWaitStates(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15.slave));

    assign bus1.req       = bus2.req;
    assign bus1.rw_n      = bus2.rw_n;
    assign bus1.padr_i    = bus2.padr_i;
    assign bus1.wp_i      = bus2.wp_i;
    assign bus1.dbi       = bus2.dbi;
    assign bus1.sram_d_i  = bus2.sram_d_i;
    assign bus15.req      = bus2.req;
    assign bus15.rw_n     = bus2.rw_n;
    assign bus15.padr_i   = bus2.padr_i;
    assign bus15.wp_i     = bus2.wp_i;
    assign bus15.dbi      = bus2.dbi;
    assign bus15.sram_d_i = bus2.sram_d_i;

    typedef struct {
        logic        rw_n;
        logic [23:0] padr;
        logic        wp;
        logic [7:0]  dbi;
        logic [7:0]  din;
        int          rdy_cyc;
        int          fault_cnt;
        int          oe_cnt;
        int          we_cnt;
        int          we_first;
        int          doe_cnt;
        logic [23:0] exp_a;
        logic [7:0]  exp_do;
        logic [7:0]  exp_dbo;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dbo"},      32'(bus2.dbo),       32'h00);
        chk({tag, "_rdy"},      32'(bus2.rdy),       32'h0);
        chk({tag, "_wp_fault"}, 32'(bus2.wp_fault),  32'h0);
        chk({tag, "_busy"},     32'(bus2.busy),      32'h0);
        chk({tag, "_sram_a"},   32'(bus2.sram_a),    32'h000000);
        chk({tag, "_sram_d_o"}, 32'(bus2.sram_d_o),  32'h00);
        chk({tag, "_strobes"},  {28'd0, bus2.sram_ce_n, bus2.sram_oe_n, bus2.sram_we_n, bus2.sram_d_oe}, 32'hE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus2.req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single-request transaction on the W=2 unit, observed for 8 cycles after the accept edge.
    task automatic do_txn(input string tag, input vec_t v);
        int rc, fc, oc, wc, wf, dc, cc, bc, ab;
        logic [7:0] do_at_rdy;
        rc = 0; fc = 0; oc = 0; wc = 0; wf = 0; dc = 0; cc = 0; bc = 0; ab = 0;
        do_at_rdy = 8'hxx;
        @(negedge clk);
        bus2.req      = 1'b1;
        bus2.rw_n     = v.rw_n;
        bus2.padr_i   = v.padr;
        bus2.wp_i     = v.wp;
        bus2.dbi      = v.dbi;
        bus2.sram_d_i = v.din;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus2.req = 1'b0;
            if (bus2.rdy && rc == 0) begin
                rc = c;
                do_at_rdy = bus2.sram_d_o;
            end
            if (bus2.wp_fault) fc++;
            if (!bus2.sram_oe_n) oc++;
            if (!bus2.sram_we_n) begin
                wc++;
                if (wf == 0) wf = c;
            end
            if (bus2.sram_d_oe) dc++;
            if (!bus2.sram_ce_n) cc++;
            if (bus2.busy) bc++;
            if (bus2.sram_a !== v.exp_a) ab++;
        end
        chk({tag, "_rdy_cycle"}, 32'(rc), 32'(v.rdy_cyc));
        chk({tag, "_fault_cnt"}, 32'(fc), 32'(v.fault_cnt));
        chk({tag, "_oe_cnt"},    32'(oc), 32'(v.oe_cnt));
        chk({tag, "_we_cnt"},    32'(wc), 32'(v.we_cnt));
        chk({tag, "_we_first"},  32'(wf), 32'(v.we_first));
        chk({tag, "_doe_cnt"},   32'(dc), 32'(v.doe_cnt));
        chk({tag, "_ce_cnt"},    32'(cc), (v.fault_cnt != 0) ? 32'd0 : 32'(v.rdy_cyc));
        chk({tag, "_busy_cnt"},  32'(bc), 32'(v.rdy_cyc));
        chk({tag, "_a_bad"},     32'(ab), 32'd0);
        chk({tag, "_d_o"},       32'(do_at_rdy), 32'(v.exp_do));
        chk({tag, "_dbo"},       32'(bus2.dbo), 32'(v.exp_dbo));
    endtask

    vec_t vecs[6];
    vec_t post;

    initial begin
        int r1, r2, nwe, nrdy, l1, l2, l15;

        bus2.req = 1'b0; bus2.rw_n = 1'b1; bus2.padr_i = 24'h0;
        bus2.wp_i = 1'b0; bus2.dbi = 8'h0; bus2.sram_d_i = 8'h0;

        //          rw  padr        wp  dbi    din    rdy f oe we wf doe a           do     dbo
        vecs[0] = '{1'b1, 24'h01F000, 1'b0, 8'h00, 8'hA5, 4, 0, 3, 0, 0, 0, 24'h01F000, 8'h00, 8'hA5};
        vecs[1] = '{1'b0, 24'h000100, 1'b0, 8'h1F, 8'h00, 4, 0, 0, 2, 2, 4, 24'h000100, 8'h1F, 8'hA5};
        vecs[2] = '{1'b0, 24'h123456, 1'b1, 8'h77, 8'h00, 1, 1, 0, 0, 0, 0, 24'h000100, 8'h1F, 8'hA5};
        vecs[3] = '{1'b1, 24'h123456, 1'b1, 8'h77, 8'h3C, 4, 0, 3, 0, 0, 0, 24'h123456, 8'h77, 8'h3C};
        vecs[4] = '{1'b1, 24'hFFFFFF, 1'b0, 8'h00, 8'h00, 4, 0, 3, 0, 0, 0, 24'hFFFFFF, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 24'hFFFFFF, 1'b0, 8'hFF, 8'h11, 4, 0, 0, 2, 2, 4, 24'hFFFFFF, 8'hFF, 8'h00};

        @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_txn($sformatf("v%0d", i), vecs[i]);
        end

        // Back-to-back: req held high across a read and then a write.
        @(negedge clk);
        bus2.req = 1'b1; bus2.rw_n = 1'b1; bus2.wp_i = 1'b0;
        bus2.padr_i = 24'h000200; bus2.sram_d_i = 8'h5A; bus2.dbi = 8'h00;
        @(posedge clk);
        r1 = 0; r2 = 0; nwe = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (!bus2.sram_we_n) nwe++;
            if (bus2.rdy) begin
                if (r1 == 0) begin
                    r1 = c;
                    chk("b2b_first_a", 32'(bus2.sram_a), 32'h000200);
                    bus2.rw_n = 1'b0; bus2.dbi = 8'hC3; bus2.padr_i = 24'h000300;
                end else if (r2 == 0) begin
                    r2 = c;
                    bus2.req = 1'b0;
                    chk("b2b_second_a",  32'(bus2.sram_a),   32'h000300);
                    chk("b2b_second_do", 32'(bus2.sram_d_o), 32'hC3);
                end
            end
        end
        chk("b2b_rdy1", 32'(r1), 32'd4);
        chk("b2b_rdy2", 32'(r2), 32'd9);
        chk("b2b_we_cnt", 32'(nwe), 32'd2);
        chk("b2b_dbo", 32'(bus2.dbo), 32'h5A);

        // Reset asserted during the first ACCESS cycle of a write.
        @(negedge clk);
        bus2.req = 1'b1; bus2.rw_n = 1'b0; bus2.wp_i = 1'b0;
        bus2.padr_i = 24'h000400; bus2.dbi = 8'h99;
        @(posedge clk);
        @(negedge clk);
        bus2.req = 1'b0;
        @(negedge clk);
        chk("midrst_we_low", 32'(bus2.sram_we_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        nrdy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus2.rdy) nrdy++;
        end
        chk("midrst_no_rdy", 32'(nrdy), 32'd0);
        post = '{1'b1, 24'h000500, 1'b0, 8'h00, 8'h42, 4, 0, 3, 0, 0, 0, 24'h000500, 8'h00, 8'h42};
        do_txn("post_rst", post);

        // Latency across the three wait-state builds from one shared accept edge.
        do_reset();
        @(negedge clk);
        bus2.req = 1'b1; bus2.rw_n = 1'b1; bus2.wp_i = 1'b0;
        bus2.padr_i = 24'h000600; bus2.sram_d_i = 8'h0F;
        @(posedge clk);
        l1 = 0; l2 = 0; l15 = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) bus2.req = 1'b0;
            if (bus1.rdy  && l1  == 0) l1  = c;
            if (bus2.rdy  && l2  == 0) l2  = c;
            if (bus15.rdy && l15 == 0) l15 = c;
        end
        chk("w1_rdy_cycle",  32'(l1),  32'd3);
        chk("w2_rdy_cycle",  32'(l2),  32'd4);
        chk("w15_rdy_cycle", 32'(l15), 32'd17);
        chk("w15_dbo", 32'(bus15.dbo), 32'h0F);
        chk("w1_dbo",  32'(bus1.dbo),  32'h0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
